mic_1rnc: RTL and testbench
===========================

MIC_1RNC -- requirements
Module: mic_1rnc

Interface
REQ-001 SHALL have parameter NUM_C, default 2, meaning the completer port count; legal values are 2 and 4.
REQ-002 SHALL have parameter SEL_LSB, default 30, meaning the lowest header-address bit used for completer select; SEL_LSB+log2(NUM_C) <= 32.
REQ-003 Ports (flattened buses, completer k at slice k):
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- R0I_TVALID/R0I_TREADY/R0I_TDATA/R0I_TLAST  in/out/in/in  1/1/64/1  requester request input.
- R0O_TVALID/R0O_TREADY/R0O_TDATA/R0O_TLAST  out/in/out/out  1/1/64/1  requester response output.
- CO_TVALID/CO_TREADY/CO_TDATA/CO_TLAST  out/in/out/out  NUM_C/NUM_C/64*NUM_C/NUM_C  completer request outputs.
- CI_TVALID/CI_TREADY/CI_TDATA/CI_TLAST  in/out/in/in  NUM_C/NUM_C/64*NUM_C/NUM_C  completer response inputs.

Function
REQ-004 A packet SHALL be the beats from the first beat after reset or after a TLAST handshake, up to and including the next TLAST beat; the first beat is the header.
REQ-005 The request route SHALL be sel = R0I_TDATA[SEL_LSB +: log2(NUM_C)] of the header beat; higher address bits are ignored (aliasing).
REQ-006 The request steer SHALL have states REQ_HDR and REQ_BODY; reset enters REQ_HDR.
REQ-007 In REQ_HDR the route SHALL be computed combinationally from the current header beat.
REQ-008 In REQ_BODY the route SHALL be the value latched at the header handshake.
REQ-009 Only CO_TVALID[route] SHALL follow R0I_TVALID; all other CO_TVALID bits SHALL be 0.
REQ-010 R0I_TREADY SHALL equal CO_TREADY[route]; the ready of a non-selected completer SHALL have no effect.
REQ-011 The header handshake with TLAST=0 SHALL enter REQ_BODY; any handshake with TLAST=1 SHALL enter REQ_HDR; a single-beat packet SHALL stay in REQ_HDR.
REQ-012 TDATA and TLAST SHALL pass unmodified; the route field SHALL not be consumed.
REQ-013 The response merge SHALL have states RSP_IDLE and RSP_LOCK.
REQ-014 In RSP_IDLE with any CI_TVALID set, the merge SHALL register grant = first valid index strictly after last_grant, round-robin modulo NUM_C, then enter RSP_LOCK.
REQ-015 In RSP_LOCK the merge SHALL forward CI[grant] to R0O with CI_TREADY[grant] = R0O_TREADY; all other CI_TREADY bits SHALL be 0.
REQ-016 R0O_TVALID SHALL be 0 in RSP_IDLE, giving a one-cycle arbitration bubble per response packet.
REQ-017 A TLAST handshake in RSP_LOCK SHALL set last_grant = grant and return to RSP_IDLE; inputs valid in that cycle SHALL be arbitrated in the following cycle.
REQ-018 The merge SHALL not switch grant mid-packet, regardless of other CI_TVALID activity.
REQ-019 Request and response paths SHALL be independent; simultaneous activity on both SHALL not stall either path.

Reset
REQ-020 With reset low, outputs SHALL be: R0I_TREADY=0, CO_TVALID=0, R0O_TVALID=0, CI_TREADY=0; state SHALL be REQ_HDR and RSP_IDLE; last_grant = NUM_C-1, so index 0 has first priority.
REQ-021 Assertion of reset mid-packet SHALL abandon the packet; the first beat after release SHALL be treated as a header.

Configuration
REQ-022 Macro MIC_1RNC_REQ_SLICE_EN defined: a 2-entry skid buffer SHALL sit on each completer request output.
- Request latency 1 cycle, full throughput.
- R0I_TREADY SHALL be independent of CO_TREADY in the same cycle.
- After reset, buffers SHALL be empty.
REQ-023 Macro MIC_1RNC_REQ_SLICE_EN undefined: the request path SHALL be combinational, 0-cycle latency, as in REQ-009 and REQ-010.

Verification
REQ-024 NUM_C=2: header addr 0x4000_1000 with 3 beats -> all beats on CO[1], CO_TVALID[0] stays 0, route held even if body beat bit 30 = 0.
REQ-025 NUM_C=4, SEL_LSB=30: headers 0x0000_0000, 0x4000_0000, 0x8000_0000, 0xC000_0000, each single-beat -> CO[0], CO[1], CO[2], CO[3] in order, with no idle cycles between packets (slice undefined).
REQ-026 NUM_C=4: all CI_TVALID held with 2-beat packets -> grants 0,1,2,3,0; each packet contiguous; one bubble between packets.
REQ-027 R0O_TREADY=0 for 5 cycles mid-packet while CI[2] is valid -> grant and data held stable; no CI_TREADY[2] asserted.
REQ-028 reset low during beat 2 of a 4-beat request -> all TVALID outputs 0; after release, next beat addr 0x4000_0000 routes to CO[1].
REQ-029 With MIC_1RNC_REQ_SLICE_EN defined: CO_TREADY toggled randomly for 1000 beats -> no beat lost or duplicated, and the header appears one cycle after acceptance.

Source files
------------

// File: rtl/mic_1rnc.sv
// mic_1rnc: one-requester / NUM_C-completer AXI-Stream interconnect.
//
// Request path: each request packet is steered to one completer. The
// completer index comes from the header beat at
// R0I_TDATA[SEL_LSB +: log2(NUM_C)], and that index is held for the rest of
// the packet.
// Response path: response packets from the completers are merged back to the
// requester. Arbitration is round-robin and happens once per packet. The
// merge locks onto the granted completer until that completer's TLAST beat
// is accepted.
//
// Parameters
//   NUM_C    completer port count (2 or 4)
//   SEL_LSB  lowest header-address bit of the completer select field
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    asynchronous, active-low reset
//   R0I_*                    requester request input stream
//   R0O_*                    requester response output stream
//   CO_*                     completer request outputs, completer k at slice k
//   CI_*                     completer response inputs, completer k at slice k
//
// Configuration macro
//   MIC_1RNC_REQ_SLICE_EN    when defined, a 2-entry skid buffer sits on each
//                            completer request output. Request latency becomes
//                            1 cycle, and R0I_TREADY no longer depends on
//                            CO_TREADY in the same cycle.

`ifdef MIC_1RNC_REQ_SLICE_EN
// Two-entry skid buffer for one completer request lane.
// Ready depends only on the occupancy register, which breaks the
// combinational ready path. Two entries keep the lane at full throughput.
module mic_1rnc_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:0] in_beat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:0] out_beat
);
    logic [64:0] mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  cnt;
    logic        push, pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_beat  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_beat;
    end
endmodule
`endif

module mic_1rnc #(
    parameter int NUM_C   = 2,
    parameter int SEL_LSB = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  R0I_TVALID,
    output logic                  R0I_TREADY,
    input  logic [63:0]           R0I_TDATA,
    input  logic                  R0I_TLAST,
    output logic                  R0O_TVALID,
    input  logic                  R0O_TREADY,
    output logic [63:0]           R0O_TDATA,
    output logic                  R0O_TLAST,
    output logic [NUM_C-1:0]      CO_TVALID,
    input  logic [NUM_C-1:0]      CO_TREADY,
    output logic [64*NUM_C-1:0]   CO_TDATA,
    output logic [NUM_C-1:0]      CO_TLAST,
    input  logic [NUM_C-1:0]      CI_TVALID,
    output logic [NUM_C-1:0]      CI_TREADY,
    input  logic [64*NUM_C-1:0]   CI_TDATA,
    input  logic [NUM_C-1:0]      CI_TLAST
);
    localparam int SW = $clog2(NUM_C);

    // ---------------------------------------------------------------- request
    typedef enum logic {REQ_HDR, REQ_BODY} req_st_t;

    req_st_t        req_st;
    logic [SW-1:0]  req_lat;
    logic [SW-1:0]  hdr_sel;
    logic [SW-1:0]  route;
    logic           req_hs;

    // Upper address bits above the select field are ignored, so the
    // completer windows alias across the address space.
    assign hdr_sel = R0I_TDATA[SEL_LSB +: SW];
    assign route   = (req_st == REQ_BODY) ? req_lat : hdr_sel;
    assign req_hs  = R0I_TVALID & R0I_TREADY;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_st  <= REQ_HDR;
            req_lat <= '0;
        end else if (req_hs) begin
            // In REQ_BODY, route already equals req_lat, so latching route
            // on every beat is harmless.
            req_lat <= route;
            req_st  <= R0I_TLAST ? REQ_HDR : REQ_BODY;
        end
    end

`ifdef MIC_1RNC_REQ_SLICE_EN
    logic [NUM_C-1:0]       sk_in_vld;
    logic [NUM_C-1:0]       sk_in_rdy;
    logic [NUM_C-1:0][64:0] sk_out;

    always_comb begin
        sk_in_vld        = '0;
        sk_in_vld[route] = R0I_TVALID;
        R0I_TREADY       = sk_in_rdy[route] & reset;
    end

    for (genvar k = 0; k < NUM_C; k++) begin : g_slice
        mic_1rnc_skid u_skid (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (sk_in_vld[k]),
            .in_ready  (sk_in_rdy[k]),
            .in_beat   ({R0I_TLAST, R0I_TDATA}),
            .out_valid (CO_TVALID[k]),
            .out_ready (CO_TREADY[k]),
            .out_beat  (sk_out[k])
        );
        assign CO_TDATA[k*64 +: 64] = sk_out[k][63:0];
        assign CO_TLAST[k]          = sk_out[k][64];
    end
`else
    // Combinational steer. The handshake outputs are gated by reset so that
    // nothing leaks out while reset is held low.
    always_comb begin
        CO_TVALID        = '0;
        CO_TVALID[route] = R0I_TVALID & reset;
        R0I_TREADY       = CO_TREADY[route] & reset;
    end

    for (genvar k = 0; k < NUM_C; k++) begin : g_pass
        assign CO_TDATA[k*64 +: 64] = R0I_TDATA;
        assign CO_TLAST[k]          = R0I_TLAST;
    end
`endif

    // --------------------------------------------------------------- response
    typedef enum logic {RSP_IDLE, RSP_LOCK} rsp_st_t;

    rsp_st_t        rsp_st;
    logic [SW-1:0]  grant;
    logic [SW-1:0]  last_grant;
    logic [SW-1:0]  pick;
    logic [SW-1:0]  idx;

    // Round-robin pick: find the first valid index strictly after
    // last_grant. The loop scans from farthest to nearest so that the
    // nearest candidate is written last and wins. NUM_C is a power of two,
    // so wrapping is just SW-bit truncation.
    always_comb begin
        pick = last_grant;
        idx  = '0;
        for (int i = NUM_C; i >= 1; i--) begin
            idx = last_grant + SW'(i);
            if (CI_TVALID[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_st     <= RSP_IDLE;
            grant      <= '0;
            last_grant <= SW'(NUM_C - 1);
        end else begin
            case (rsp_st)
                RSP_IDLE: begin
                    if (|CI_TVALID) begin
                        grant  <= pick;
                        rsp_st <= RSP_LOCK;
                    end
                end
                RSP_LOCK: begin
                    if (R0O_TVALID && R0O_TREADY && R0O_TLAST) begin
                        last_grant <= grant;
                        rsp_st     <= RSP_IDLE;
                    end
                end
                default: rsp_st <= RSP_IDLE;
            endcase
        end
    end

    // Output is held off in IDLE; this produces the one-cycle bubble
    // between response packets.
    always_comb begin
        R0O_TVALID = (rsp_st == RSP_LOCK) & CI_TVALID[grant];
        R0O_TDATA  = CI_TDATA[int'(grant)*64 +: 64];
        R0O_TLAST  = CI_TLAST[grant];
        CI_TREADY  = '0;
        if (rsp_st == RSP_LOCK) CI_TREADY[grant] = R0O_TREADY;
    end

endmodule

// File: tb/tb_mic_1rnc.sv
// Self-checking bench for mic_1rnc (NUM_C=4, SEL_LSB=30).
// Random and directed stimulus is scored against a packet-level reference
// model. Request beats are routed by the header address field. Response
// packets are granted round-robin, one packet at a time, with a bubble
// between packets.
module tb_mic_1rnc;
    localparam int NC = 4;
    localparam int SL = 30;

    logic clk, reset;
    logic R0I_TVALID, R0I_TREADY, R0I_TLAST;
    logic [63:0] R0I_TDATA;
    logic R0O_TVALID, R0O_TREADY, R0O_TLAST;
    logic [63:0] R0O_TDATA;
    logic [NC-1:0] CO_TVALID, CO_TREADY, CO_TLAST;
    logic [64*NC-1:0] CO_TDATA;
    logic [NC-1:0] CI_TVALID, CI_TREADY, CI_TLAST;
    logic [64*NC-1:0] CI_TDATA;

    mic_1rnc #(.NUM_C(NC), .SEL_LSB(SL)) dut (
        .clk(clk), .reset(reset),
        .R0I_TVALID(R0I_TVALID), .R0I_TREADY(R0I_TREADY), .R0I_TDATA(R0I_TDATA), .R0I_TLAST(R0I_TLAST),
        .R0O_TVALID(R0O_TVALID), .R0O_TREADY(R0O_TREADY), .R0O_TDATA(R0O_TDATA), .R0O_TLAST(R0O_TLAST),
        .CO_TVALID(CO_TVALID), .CO_TREADY(CO_TREADY), .CO_TDATA(CO_TDATA), .CO_TLAST(CO_TLAST),
        .CI_TVALID(CI_TVALID), .CI_TREADY(CI_TREADY), .CI_TDATA(CI_TDATA), .CI_TLAST(CI_TLAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus queues and reference model state
    logic [64:0] req_q[$];
    logic [64:0] exp_req[NC][$];
    int          exp_cyc[NC][$];
    logic [64:0] rsp_q[NC][$];
    int          co_log[$];
    int          co_log_cyc[$];
    int          gnt_log[$];
    bit          log_en = 0;
    int          co_total = 0;
    int          req_pct = 100, co_pct = 100, r0o_pct = 100;
    bit          req_hs;
    bit [NC-1:0] rsp_hs;
    bit          m_body, m_lock, m_first;
    int          m_route, m_grant, m_lg;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sel_of(input logic [63:0] d);
        return int'((d >> SL) % NC);
    endfunction

    function automatic int rr_pick(input int lg, input logic [NC-1:0] v);
        for (int i = 1; i <= NC; i++)
            if (v[(lg + i) % NC]) return (lg + i) % NC;
        return lg;
    endfunction

    function automatic bit busy();
        bit b = m_lock || (req_q.size() > 0);
        for (int k = 0; k < NC; k++)
            if (exp_req[k].size() > 0 || rsp_q[k].size() > 0) b = 1;
        return b;
    endfunction

    // Sample everything at the falling edge; inputs are stable there until
    // the next rising edge.
    task automatic monitor();
        int cr, lat;
        logic [64:0] b;
        bit ev;
        req_hs = R0I_TVALID && R0I_TREADY;
        cr = m_body ? m_route : sel_of(R0I_TDATA);
`ifndef MIC_1RNC_REQ_SLICE_EN
        chk("co_tvalid", 72'(CO_TVALID), R0I_TVALID ? 72'(1 << cr) : 72'd0);
        chk("r0i_tready", 72'(R0I_TREADY), 72'(CO_TREADY[cr]));
`endif
        if (req_hs) begin
            exp_req[cr].push_back({R0I_TLAST, R0I_TDATA});
            exp_cyc[cr].push_back(cyc);
            m_body  = !R0I_TLAST;
            m_route = cr;
        end
        for (int k = 0; k < NC; k++) begin
            if (CO_TVALID[k] && CO_TREADY[k]) begin
                co_total++;
                if (log_en) begin co_log.push_back(k); co_log_cyc.push_back(cyc); end
                if (exp_req[k].size() == 0) chk("co_extra_beat", 72'(exp_req[k].size()), 72'd1);
                else begin
                    b   = exp_req[k].pop_front();
                    lat = cyc - exp_cyc[k].pop_front();
                    chk("co_beat", 72'({CO_TLAST[k], CO_TDATA[k*64 +: 64]}), 72'(b));
`ifdef MIC_1RNC_REQ_SLICE_EN
                    chk("co_latency_ge1", 72'(lat >= 1), 72'd1);
`else
                    chk("co_latency", 72'(lat), 72'd0);
`endif
                end
            end
        end
        // response merge
        for (int k = 0; k < NC; k++) rsp_hs[k] = CI_TVALID[k] && CI_TREADY[k];
        if (!m_lock) begin
            chk("rsp_bubble", 72'(R0O_TVALID), 72'd0);
            chk("ci_tready_idle", 72'(CI_TREADY), 72'd0);
            if (|CI_TVALID) begin
                m_grant = rr_pick(m_lg, CI_TVALID);
                m_lock  = 1;
            end
        end else begin
            ev = rsp_q[m_grant].size() > 0;
            chk("r0o_tvalid", 72'(R0O_TVALID), 72'(ev));
            chk("ci_tready", 72'(CI_TREADY), R0O_TREADY ? 72'(1 << m_grant) : 72'd0);
            if (ev) begin
                b = rsp_q[m_grant][0];
                chk("r0o_beat", 72'({R0O_TLAST, R0O_TDATA}), 72'(b));
                if (R0O_TREADY) begin
                    if (m_first) gnt_log.push_back(m_grant);
                    m_first = 0;
                    if (b[64]) begin m_lg = m_grant; m_lock = 0; m_first = 1; end
                end
            end
        end
    endtask

    task automatic drive();
        if (req_hs) req_q.delete(0);
        if (req_q.size() > 0) begin
            if (!R0I_TVALID || req_hs) R0I_TVALID = ($urandom_range(99) < req_pct);
            {R0I_TLAST, R0I_TDATA} = req_q[0];
        end else begin
            R0I_TVALID = 0;
            R0I_TLAST  = 0;
            R0I_TDATA  = '0;
        end
        for (int k = 0; k < NC; k++) begin
            CO_TREADY[k] = ($urandom_range(99) < co_pct);
            if (rsp_hs[k]) rsp_q[k].delete(0);
            CI_TVALID[k] = rsp_q[k].size() > 0;
            {CI_TLAST[k], CI_TDATA[k*64 +: 64]} = (rsp_q[k].size() > 0) ? rsp_q[k][0] : 65'd0;
        end
        R0O_TREADY = ($urandom_range(99) < r0o_pct);
        req_hs = 0;
        rsp_hs = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset      = 0;
        R0I_TVALID = 1;
        CO_TREADY  = '1;
        CI_TVALID  = '1;
        R0O_TREADY = 1;
        #2;
        chk("rst_r0i_tready", 72'(R0I_TREADY), 72'd0);
        chk("rst_co_tvalid", 72'(CO_TVALID), 72'd0);
        chk("rst_r0o_tvalid", 72'(R0O_TVALID), 72'd0);
        chk("rst_ci_tready", 72'(CI_TREADY), 72'd0);
        req_q.delete();
        for (int k = 0; k < NC; k++) begin
            exp_req[k].delete();
            exp_cyc[k].delete();
            rsp_q[k].delete();
        end
        m_body = 0; m_lock = 0; m_first = 1; m_lg = NC - 1; m_route = 0; m_grant = 0;
        req_hs = 0; rsp_hs = '0;
        repeat (2) @(posedge clk);
        #1;
        R0I_TVALID = 0; R0I_TLAST = 0; R0I_TDATA = '0;
        CI_TVALID = '0; CI_TLAST = '0; CI_TDATA = '0;
        #2 reset = 1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (busy() && n < maxc) begin tick(); n++; end
        chk("drain_timeout", 72'(n < maxc), 72'd1);
    endtask

    initial begin
        int n, len, pushed;
        logic [63:0] d;
        reset = 0;
        R0I_TVALID = 0; R0I_TDATA = '0; R0I_TLAST = 0;
        R0O_TREADY = 0; CO_TREADY = '0;
        CI_TVALID = '0; CI_TDATA = '0; CI_TLAST = '0;
        #3;
        do_reset();

        // header 0x4000_1000, 3 beats, body bit 30 clear: all on CO[1]
        co_pct = 70; req_pct = 100;
        log_en = 1; co_log.delete(); co_log_cyc.delete();
        req_q.push_back({1'b0, 64'h0000_0000_4000_1000});
        req_q.push_back({1'b0, 64'h0000_0000_0000_0005});
        req_q.push_back({1'b1, 64'hFFFF_FFFF_0000_0007});
        drain(200);
        chk("t24_beats", 72'(co_log.size()), 72'd3);
        foreach (co_log[i]) chk("t24_route", 72'(co_log[i]), 72'd1);

        // four single-beat packets back to back: CO[0..3] on consecutive cycles
        co_pct = 100;
        co_log.delete(); co_log_cyc.delete();
        req_q.push_back({1'b1, 64'h0000_0000_0000_0000});
        req_q.push_back({1'b1, 64'h0000_0000_4000_0000});
        req_q.push_back({1'b1, 64'h0000_0000_8000_0000});
        req_q.push_back({1'b1, 64'h0000_0000_C000_0000});
        drain(200);
        chk("t25_beats", 72'(co_log.size()), 72'd4);
        foreach (co_log[i]) begin
            chk("t25_route", 72'(co_log[i]), 72'(i));
            chk("t25_no_gap", 72'(co_log_cyc[i] - co_log_cyc[0]), 72'(i));
        end
        log_en = 0;

        // all completers valid with two 2-beat packets each: grants rotate
        r0o_pct = 100;
        gnt_log.delete();
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    rsp_q[k].push_back({b == 1, 64'hA500_0000_0000_0000 | 64'(k * 256 + p * 16 + b)});
        drain(200);
        chk("t26_pkts", 72'(gnt_log.size()), 72'd8);
        foreach (gnt_log[i]) chk("t26_grant", 72'(gnt_log[i]), 72'(i % NC));

        // back-pressure mid-packet on CI[2]: nothing consumed, grant held
        for (int b = 0; b < 4; b++) rsp_q[2].push_back({b == 3, 64'h2222_0000_0000_0000 | 64'(b)});
        n = 0;
        while (rsp_q[2].size() != 3 && n < 20) begin tick(); n++; end
        chk("t27_first_beat", 72'(n < 20), 72'd1);
        r0o_pct = 0; R0O_TREADY = 0;
        repeat (5) tick();
        chk("t27_held", 72'(rsp_q[2].size()), 72'd3);
        chk("t27_grant", 72'(m_grant), 72'd2);
        r0o_pct = 100;
        drain(200);

        // reset during beat 2 of a 4-beat request; next header routes fresh
        co_pct = 100; req_pct = 100;
        req_q.push_back({1'b0, 64'h0000_0000_C000_0000});
        req_q.push_back({1'b0, 64'h1});
        req_q.push_back({1'b0, 64'h2});
        req_q.push_back({1'b1, 64'h3});
        n = 0;
        while (req_q.size() != 3 && n < 20) begin tick(); n++; end
        chk("t28_first_beat", 72'(n < 20), 72'd1);
        do_reset();
        log_en = 1; co_log.delete(); co_log_cyc.delete();
        req_q.push_back({1'b1, 64'h0000_0000_4000_0000});
        drain(200);
        chk("t28_beats", 72'(co_log.size()), 72'd1);
        if (co_log.size() > 0) chk("t28_route", 72'(co_log[0]), 72'd1);
        log_en = 0;

        // random traffic on both paths at once
        co_pct = 60; req_pct = 70; r0o_pct = 70;
        co_total = 0; pushed = 0;
        for (int p = 0; p < 400; p++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
                d = {$urandom, $urandom};
                req_q.push_back({b == len - 1, d});
                pushed++;
            end
        end
        for (int p = 0; p < 80; p++) begin
            n   = $urandom_range(NC - 1);
            len = $urandom_range(3, 1);
            for (int b = 0; b < len; b++) begin
                d = {$urandom, $urandom};
                rsp_q[n].push_back({b == len - 1, d});
            end
        end
        drain(30000);
        chk("rand_beat_count", 72'(co_total), 72'(pushed));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
